// File: rtl/ifetch_unit_if.sv
// Instruction-memory fetch bus: single outstanding request, req/gnt handshake,
// read data returned one or more cycles after the handshake.
interface ifetch_unit_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;

    // Fetch unit side
    modport master (
        output im_req,
        output im_addr,
        input  im_gnt,
        input  im_rvalid,
        input  im_rdata
    );

    // Instruction memory side
    modport slave (
        input  im_req,
        input  im_addr,
        output im_gnt,
        output im_rvalid,
        output im_rdata
    );
endinterface

// File: rtl/ifetch_unit.sv
// RV32 instruction-fetch stage: PC register, single-outstanding word fetch,
// IF/ID register with a 1-entry skid buffer for stalls, and redirect handling
// that squashes any stale in-flight response.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    ifetch_unit_if.master      bus,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               if_valid,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_instr
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] req_pc;

    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;

    logic        handshake;
    logic        rsp_accept;
    logic        skid_fill;
    logic        ifid_load;

    // Request is masked while the skid holds an instruction or a redirect is
    // retargeting the PC; reset also forces it low asynchronously.
    always_comb begin
        bus.im_req  = (state == ST_REQ) && !skid_valid && !redirect_valid && !rst;
        bus.im_addr = pc;
    end

    // Handshake and response acceptance qualifiers
    always_comb begin
        handshake  = bus.im_req && bus.im_gnt;
        rsp_accept = (state == ST_WAIT) && bus.im_rvalid && !redirect_valid;
        ifid_load  = !stall || !if_valid;
        skid_fill  = rsp_accept && !ifid_load;
    end

    // PC, outstanding-request address and fetch state machine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            req_pc <= '0;
            state  <= ST_REQ;
        end else if (redirect_valid) begin
            pc <= redirect_pc & ~32'd3;
            // A fetch still in flight must have its response thrown away.
            if (state != ST_REQ && !bus.im_rvalid)
                state <= ST_DROP;
            else
                state <= ST_REQ;
        end else begin
            case (state)
                ST_REQ: begin
                    if (handshake) begin
                        pc     <= pc + 32'd4;
                        req_pc <= pc;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.im_rvalid)
                        state <= ST_REQ;
                end
                ST_DROP: begin
                    if (bus.im_rvalid)
                        state <= ST_REQ;
                end
                default: state <= ST_REQ;
            endcase
        end
    end

    // Skid buffer: catches a response that arrives while decode is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= NOP_INSTR;
        end else if (redirect_valid) begin
            skid_valid <= 1'b0;
        end else if (skid_fill) begin
            skid_valid <= 1'b1;
            skid_pc    <= req_pc;
            skid_instr <= bus.im_rdata;
        end else if (!stall && skid_valid) begin
            skid_valid <= 1'b0;
        end
    end

    // IF/ID register: skid drains first, then a fresh response, else a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= NOP_INSTR;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
        end else if (ifid_load) begin
            if (skid_valid) begin
                if_valid <= 1'b1;
                if_pc    <= skid_pc;
                if_instr <= skid_instr;
            end else if (rsp_accept) begin
                if_valid <= 1'b1;
                if_pc    <= req_pc;
                if_instr <= bus.im_rdata;
            end else begin
                if_valid <= 1'b0;
                if_instr <= NOP_INSTR;
            end
        end
    end

    // Memory must not grant while a redirect masks the request
    a_no_gnt_on_redirect: assert property (@(posedge clk) disable iff (rst)
        !((state == ST_REQ) && redirect_valid && bus.im_gnt));

    // Read data is only legal while a fetch is outstanding or being dropped
    a_no_rvalid_in_req: assert property (@(posedge clk) disable iff (rst)
        !((state == ST_REQ) && bus.im_rvalid));

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage of the RV32 pipeline: holds the PC, issues word reads to instruction memory, and registers the fetched word into the IF/ID register that feeds the decoder's `instr` input.
- Handles pipeline stalls from the hazard unit, with a 1-entry skid buffer.
- Handles taken-branch/jump redirects from EX, discarding any stale in-flight fetch.
- Allows one outstanding memory request at a time.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble value (addi x0,x0,0) driven on if_instr when invalid.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold IF/ID contents; decode cannot accept.
- redirect_valid  input  1  taken branch/jump; flush IF/ID and reload PC.
- redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 00).
- im_req  output  1  fetch request to instruction memory.
- im_addr  output  32  word-aligned fetch address, valid while im_req=1.
- im_gnt  input  1  memory accepts the request this cycle (im_req & im_gnt = handshake).
- im_rvalid  input  1  read data valid; arrives ≥1 cycle after the handshake.
- im_rdata  input  32  fetched instruction.
- if_valid  output  1  IF/ID holds a real instruction.
- if_pc  output  32  PC of if_instr.
- if_instr  output  32  instruction to decoder; NOP_INSTR when if_valid=0.

Behaviour:
- Reset (async, any state):
  - pc=RESET_PC; state=REQ.
  - if_valid=0, if_pc=0, if_instr=NOP_INSTR.
  - skid empty; im_req=0 while rst=1.
- State REQ:
  - im_req=1 and im_addr=pc (combinational), unless the skid is full or redirect_valid=1.
  - On handshake: pc<=pc+4 (mod 2^32, wrap FFFFFFFC→0); req_pc<=pc; go WAIT.
  - im_addr may change before grant (the memory samples only on the handshake).
- State WAIT:
  - im_req=0.
  - On im_rvalid, if stall=0 or if_valid=0: IF/ID loads {1, req_pc, im_rdata}; go REQ.
  - On im_rvalid with stall=1 and if_valid=1: capture into skid {req_pc, im_rdata}; go REQ; REQ suppresses im_req until the skid drains.
- State DROP:
  - im_req=0.
  - Next im_rvalid is discarded (IF/ID and skid unchanged), then go REQ.
- IF/ID update when stall=0 and no redirect:
  - If the skid is full: load from the skid, skid empties.
  - Else if an im_rvalid is accepted: load the response.
  - Else: if_valid<=0, if_instr<=NOP_INSTR (if_pc holds).
  - When stall=1, IF/ID holds all values.
- Redirect (redirect_valid=1) has priority over stall and over every other event:
  - pc<=redirect_pc & ~3.
  - if_valid<=0, if_instr<=NOP_INSTR; skid cleared.
  - If in WAIT without im_rvalid this cycle: go DROP.
  - If in WAIT with im_rvalid this cycle: the data is discarded; go REQ.
  - In REQ, im_req is forced 0 that cycle; a stray im_gnt is illegal and asserted against.
  - The new address is requested from the next cycle.
- im_rvalid in REQ state is a protocol error (assertion); it is ignored.
- Throughput: max 1 instruction per 2 cycles (grant same cycle, rvalid next cycle).
- No combinational path from stall or im_rdata to if_* outputs. im_req/im_addr depend combinationally only on state, pc, skid status and redirect_valid.

Test Plan:
- Reset release, RESET_PC=0, im_gnt=1, rvalid one cycle later with 0x00500093 → im_addr=0, then if_valid=1, if_pc=0, if_instr=0x00500093; next im_addr=0x4.
- Stall=1 with if_valid=1 and a fetch of 0x4 in flight (rdata 0x00100113) → skid filled, im_req stays 0. Release stall → if_pc=0x4, if_instr=0x00100113; next im_addr=0x8.
- Redirect to 0x103 while WAIT on a fetch of 0x8 → if_valid=0, stale rvalid dropped (if_instr stays NOP), next im_addr=0x100.
- Redirect to 0xFFFFFFFC, fetch completes → if_pc=0xFFFFFFFC; next im_addr=0x00000000.
- Redirect, stall and im_rvalid all in one cycle → IF/ID becomes a bubble, skid empty, response discarded, next im_addr=redirect target.
- rst asserted mid-WAIT, asynchronously between edges → if_valid=0, if_instr=NOP_INSTR, im_req=0 immediately. After release, the first im_addr=RESET_PC and a late rvalid is ignored.
